handshake_trace_client: RTL and testbench
=========================================

# handshake_trace_client

Active-open side of the handshake-only test harness. Generates a programmed number of TCP SYN headers towards a remote host and waits for each reply on a header receive interface. The reply is normally produced by the echo responder on the far side of the engine. For each reply the block checks the port pair and the acknowledgement number, sends the closing ACK, and keeps pass/fail counters for the trace bench.

## Interface
Parameters:
- NUM_CONN, 4: connections opened per run; must be ≥1, max 255.
- TIMEOUT_CYCLES, 1024: cycles to wait for a reply before failing a connection.
- BASE_SRC_PORT, 16'd40000: local port of connection 0; connection i uses BASE_SRC_PORT+i.
- ISN_BASE, 32'h1000_0000: initial sequence number of connection 0; ISN(i) = ISN_BASE + (i<<16), modulo 2^32.

Ports:
- clk  in  1  sole clock.
- rst_n  in  1  reset: asynchronous, active-low.
- start  in  1  one-cycle pulse that begins a run.
- cfg_src_ip  in  `IP_ADDR_WIDTH  local IP; sampled on an accepted start.
- cfg_dst_ip  in  `IP_ADDR_WIDTH  remote IP; sampled on an accepted start.
- cfg_dst_port  in  16  remote port; sampled on an accepted start.
- tx_tcp_hdr_val  out  1  outgoing header valid.
- tx_src_ip  out  `IP_ADDR_WIDTH  latched cfg_src_ip.
- tx_dst_ip  out  `IP_ADDR_WIDTH  latched cfg_dst_ip.
- tx_tcp_hdr  out  `TCP_HEADER_WIDTH  outgoing tcp_packet_header.
- tx_tcp_hdr_rdy  in  1  downstream accepts when val&&rdy.
- rx_tcp_hdr_val  in  1  incoming header valid.
- rx_tcp_hdr  in  `TCP_HEADER_WIDTH  incoming tcp_packet_header.
- rx_tcp_hdr_rdy  out  1  client accepts when val&&rdy.
- busy  out  1  a run is in progress.
- done  out  1  run complete; held until the next accepted start.
- pass_count  out  8  handshakes completed; saturates at 255.
- fail_count  out  8  bad replies plus timeouts; saturates at 255.

## Operation
State machine states: IDLE, SEND_SYN, WAIT_RESP, SEND_ACK, NEXT, DONE.
- IDLE / DONE, when start is seen:
  - latch the cfg_* inputs;
  - clear idx, pass_count and fail_count;
  - go to SEND_SYN.
- start is ignored in every other state.
- SEND_SYN: drive tx_tcp_hdr_val=1 with this header:
  - src_port = BASE_SRC_PORT+idx;
  - dst_port = cfg_dst_port;
  - seq_num = ack_num = ISN(idx);
  - flags = SYN only;
  - all other fields zero.
  - On the tx handshake: go to WAIT_RESP and clear the timeout counter.
- WAIT_RESP: the timeout counter increments every cycle. On an rx handshake the reply is good only if all three hold:
  - rx.src_port == cfg_dst_port;
  - rx.dst_port == BASE_SRC_PORT+idx;
  - rx.ack_num == ISN(idx)+1.
  - Good reply: latch rx.seq_num and go to SEND_ACK.
  - Bad reply: fail_count++ and go to NEXT.
  - Counter reaches TIMEOUT_CYCLES-1 with no handshake: fail_count++ and go to NEXT.
  - An rx handshake in that same cycle wins over the timeout.
- SEND_ACK: drive a header with:
  - the same ports as the SYN;
  - seq_num = ISN(idx)+1;
  - ack_num = latched rx.seq_num + 1, modulo 2^32;
  - flags = ACK only.
  - On the tx handshake: pass_count++ and go to NEXT.
- NEXT: if idx == NUM_CONN-1 go to DONE, else idx++ and go to SEND_SYN. Takes one cycle, no outputs.
- DONE: done=1 and busy=0.
- rx_tcp_hdr_rdy is 1 in every state out of reset. Headers accepted outside WAIT_RESP are discarded and do not change any counter.
- Flag bits are not checked on the reply.

## Timing
- Reset values (rst_n low, asynchronous): state IDLE; tx_tcp_hdr_val=0; tx_tcp_hdr=0; tx_src_ip=0; tx_dst_ip=0; busy=0; done=0; pass_count=0; fail_count=0; rx_tcp_hdr_rdy=0.
- rx_tcp_hdr_rdy rises one cycle after rst_n deasserts.
- Start to first SYN: start at cycle N gives tx_tcp_hdr_val=1 at N+1. busy=1 from N+1 until DONE is entered.
- tx outputs come from registers. While val&&!rdy, tx_tcp_hdr, tx_src_ip and tx_dst_ip must not change, and val is never dropped before the handshake.
- Reply to ACK: a good reply at cycle M gives the ACK valid at M+1.
- Per-connection minimum is 4 cycles: SYN, one cycle of WAIT_RESP, ACK, NEXT.
- A timed-out connection spends exactly TIMEOUT_CYCLES cycles in WAIT_RESP.
- Counters stay at 255 once saturated.
- Reset in any state returns immediately to the reset values; a new start is required afterwards.

## Test plan
- Loopback through an echo model (ports swapped, ack+1, 1-cycle delay), NUM_CONN=4, tx_rdy=1 → 4 SYN/ACK pairs:
  - SYN src_ports 40000..40003 with seq 0x1000_0000, 0x1001_0000, 0x1002_0000, 0x1003_0000;
  - ACK ack_num = SYN seq + 1;
  - end state pass=4, fail=0, done=1.
- tx_rdy held low for 5 cycles during SYN 0 → val stays 1 and the header is bit-identical all 5 cycles; exactly one SYN is counted.
- Reply to connection 1 with ack_num = ISN+2 → fail_count=1, no ACK for connection 1, next header is the SYN for connection 2 with src_port 40002.
- No reply to connection 0, TIMEOUT_CYCLES=16 → the connection 1 SYN appears 16+1 cycles after the SYN 0 handshake; fail=1.
- start pulsed while busy, and a stray rx header during SEND_SYN → both ignored; the run's final counts are unchanged.
- rst_n low for 1 cycle during WAIT_RESP → all outputs at reset values; no tx activity until the next start, which begins again from connection 0.

Source files
------------

// File: rtl/handshake_trace_client.sv
// Active-open side of the handshake trace harness: sends SYNs, checks each reply,
// closes with an ACK and keeps saturating pass/fail counters.
//
// state       | meaning
// IDLE        | waiting for start after reset
// SEND_SYN    | SYN header held on tx until accepted
// WAIT_RESP   | waiting for a reply, timeout counter running
// SEND_ACK    | closing ACK held on tx until accepted
// NEXT        | advance to next connection or finish
// DONE        | run complete, counters frozen until next start
`ifndef IP_ADDR_WIDTH
`define IP_ADDR_WIDTH 32
`endif
`ifndef TCP_HEADER_WIDTH
`define TCP_HEADER_WIDTH 160
`endif

module handshake_trace_client #(
    parameter int          NUM_CONN       = 4,
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [15:0] BASE_SRC_PORT  = 16'd40000,
    parameter logic [31:0] ISN_BASE       = 32'h1000_0000
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [`IP_ADDR_WIDTH-1:0]    cfg_src_ip,
    input  logic [`IP_ADDR_WIDTH-1:0]    cfg_dst_ip,
    input  logic [15:0]                  cfg_dst_port,
    output logic                         tx_tcp_hdr_val,
    output logic [`IP_ADDR_WIDTH-1:0]    tx_src_ip,
    output logic [`IP_ADDR_WIDTH-1:0]    tx_dst_ip,
    output logic [`TCP_HEADER_WIDTH-1:0] tx_tcp_hdr,
    input  logic                         tx_tcp_hdr_rdy,
    input  logic                         rx_tcp_hdr_val,
    input  logic [`TCP_HEADER_WIDTH-1:0] rx_tcp_hdr,
    output logic                         rx_tcp_hdr_rdy,
    output logic                         busy,
    output logic                         done,
    output logic [7:0]                   pass_count,
    output logic [7:0]                   fail_count
);

    typedef struct packed {
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [31:0] seq_num;
        logic [31:0] ack_num;
        logic [3:0]  data_offset;
        logic [2:0]  reserved;
        logic [8:0]  flags;
        logic [15:0] window;
        logic [15:0] checksum;
        logic [15:0] urg_ptr;
    } tcp_hdr_t;

    typedef enum logic [2:0] {
        IDLE, SEND_SYN, WAIT_RESP, SEND_ACK, NEXT, DONE
    } state_t;

    localparam logic [8:0] FLAG_SYN = 9'h002;
    localparam logic [8:0] FLAG_ACK = 9'h010;
    localparam int         TW       = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [7:0]    LAST_IDX = 8'(NUM_CONN - 1);

    state_t        state, state_next;
    logic [7:0]    idx;
    logic [TW-1:0] to_cnt;
    logic [15:0]   dst_port_q;
    tcp_hdr_t      rx_hdr, syn_hdr, ack_hdr;
    logic [7:0]    syn_idx;
    logic [15:0]   syn_dport;
    logic          tx_hs, rx_hs, reply_good;
    logic          start_run, syn_load, ack_load, tx_done, pass_inc, fail_inc, idx_inc;
    logic          unused_rx;

    function automatic logic [31:0] isn_of(input logic [7:0] i);
        return ISN_BASE + {8'd0, i, 16'd0};
    endfunction

    function automatic logic [15:0] port_of(input logic [7:0] i);
        return BASE_SRC_PORT + {8'd0, i};
    endfunction

    assign rx_hdr    = tcp_hdr_t'(rx_tcp_hdr);
    assign unused_rx = ^{rx_hdr.data_offset, rx_hdr.reserved, rx_hdr.flags,
                         rx_hdr.window, rx_hdr.checksum, rx_hdr.urg_ptr};
    assign tx_hs     = tx_tcp_hdr_val && tx_tcp_hdr_rdy;
    assign rx_hs     = rx_tcp_hdr_val && rx_tcp_hdr_rdy;
    assign reply_good = (rx_hdr.src_port == dst_port_q) &&
                        (rx_hdr.dst_port == port_of(idx)) &&
                        (rx_hdr.ack_num  == isn_of(idx) + 32'd1);

    assign busy = (state != IDLE) && (state != DONE);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        start_run  = 1'b0;
        syn_load   = 1'b0;
        ack_load   = 1'b0;
        tx_done    = 1'b0;
        pass_inc   = 1'b0;
        fail_inc   = 1'b0;
        idx_inc    = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    start_run  = 1'b1;
                    syn_load   = 1'b1;
                    state_next = SEND_SYN;
                end
            end
            SEND_SYN: begin
                if (tx_hs) begin
                    tx_done    = 1'b1;
                    state_next = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                // A reply arriving on the last timeout cycle still counts.
                if (rx_hs) begin
                    if (reply_good) begin
                        ack_load   = 1'b1;
                        state_next = SEND_ACK;
                    end else begin
                        fail_inc   = 1'b1;
                        state_next = NEXT;
                    end
                end else if (to_cnt == TO_LAST) begin
                    fail_inc   = 1'b1;
                    state_next = NEXT;
                end
            end
            SEND_ACK: begin
                if (tx_hs) begin
                    tx_done    = 1'b1;
                    pass_inc   = 1'b1;
                    state_next = NEXT;
                end
            end
            NEXT: begin
                if (idx == LAST_IDX) begin
                    state_next = DONE;
                end else begin
                    idx_inc    = 1'b1;
                    syn_load   = 1'b1;
                    state_next = SEND_SYN;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // The first SYN is built from the live cfg inputs since they latch on the same edge.
    always_comb begin
        syn_idx   = start_run ? 8'd0 : idx + 8'd1;
        syn_dport = start_run ? cfg_dst_port : dst_port_q;

        syn_hdr          = '0;
        syn_hdr.src_port = port_of(syn_idx);
        syn_hdr.dst_port = syn_dport;
        syn_hdr.seq_num  = isn_of(syn_idx);
        syn_hdr.ack_num  = isn_of(syn_idx);
        syn_hdr.flags    = FLAG_SYN;

        ack_hdr          = '0;
        ack_hdr.src_port = port_of(idx);
        ack_hdr.dst_port = dst_port_q;
        ack_hdr.seq_num  = isn_of(idx) + 32'd1;
        ack_hdr.ack_num  = rx_hdr.seq_num + 32'd1;
        ack_hdr.flags    = FLAG_ACK;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_tcp_hdr_val <= 1'b0;
            tx_tcp_hdr     <= '0;
            tx_src_ip      <= '0;
            tx_dst_ip      <= '0;
            dst_port_q     <= '0;
            idx            <= '0;
            to_cnt         <= '0;
            pass_count     <= '0;
            fail_count     <= '0;
            rx_tcp_hdr_rdy <= 1'b0;
        end else begin
            rx_tcp_hdr_rdy <= 1'b1;
            to_cnt         <= (state == WAIT_RESP) ? to_cnt + 1'b1 : '0;
            if (start_run) begin
                tx_src_ip  <= cfg_src_ip;
                tx_dst_ip  <= cfg_dst_ip;
                dst_port_q <= cfg_dst_port;
                idx        <= '0;
                pass_count <= '0;
                fail_count <= '0;
            end
            if (idx_inc) idx <= idx + 8'd1;
            if (syn_load) begin
                tx_tcp_hdr     <= syn_hdr;
                tx_tcp_hdr_val <= 1'b1;
            end else if (ack_load) begin
                tx_tcp_hdr     <= ack_hdr;
                tx_tcp_hdr_val <= 1'b1;
            end else if (tx_done) begin
                tx_tcp_hdr_val <= 1'b0;
            end
            if (pass_inc && pass_count != 8'hFF) pass_count <= pass_count + 8'd1;
            if (fail_inc && fail_count != 8'hFF) fail_count <= fail_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_handshake_trace_client.sv
// Directed bench for handshake_trace_client: echo loopback, stalls, bad replies,
// timeouts, ignored start/stray headers and mid-run reset.
`timescale 1ns/1ps
`ifndef IP_ADDR_WIDTH
`define IP_ADDR_WIDTH 32
`endif
`ifndef TCP_HEADER_WIDTH
`define TCP_HEADER_WIDTH 160
`endif

module tb_handshake_trace_client;

    localparam int          NC    = 4;
    localparam int          TO    = 16;
    localparam logic [15:0] BASE  = 16'd40000;
    localparam logic [15:0] DPORT = 16'd7;
    localparam logic [8:0]  F_SYN = 9'h002;
    localparam logic [8:0]  F_ACK = 9'h010;

    typedef struct packed {
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [31:0] seq_num;
        logic [31:0] ack_num;
        logic [3:0]  data_offset;
        logic [2:0]  reserved;
        logic [8:0]  flags;
        logic [15:0] window;
        logic [15:0] checksum;
        logic [15:0] urg_ptr;
    } hdr_t;

    logic                         clk, rst_n, start;
    logic [`IP_ADDR_WIDTH-1:0]    cfg_src_ip, cfg_dst_ip;
    logic [15:0]                  cfg_dst_port;
    logic                         tx_tcp_hdr_val, tx_tcp_hdr_rdy;
    logic [`IP_ADDR_WIDTH-1:0]    tx_src_ip, tx_dst_ip;
    logic [`TCP_HEADER_WIDTH-1:0] tx_tcp_hdr;
    logic                         rx_tcp_hdr_val, rx_tcp_hdr_rdy;
    logic [`TCP_HEADER_WIDTH-1:0] rx_tcp_hdr;
    logic                         busy, done;
    logic [7:0]                   pass_count, fail_count;

    logic [31:0] isn_tab  [4] = '{32'h1000_0000, 32'h1001_0000, 32'h1002_0000, 32'h1003_0000};
    logic [31:0] echo_seq [4] = '{32'hFFFF_FFFF, 32'h0000_1234, 32'h8000_0000, 32'h7FFF_FFFF};
    logic [31:0] ack_tab  [4] = '{32'h0000_0000, 32'h0000_1235, 32'h8000_0001, 32'h8000_0000};

    int   err_cnt = 0;
    int   chk_cnt = 0;
    int   cyc = 0;
    bit   echo_en = 1'b1;
    int   skip_idx = -1;
    int   bad_idx = -1;
    hdr_t log_q[$];
    int   log_cyc[$];
    hdr_t exp_q[$];

    handshake_trace_client #(
        .NUM_CONN(NC), .TIMEOUT_CYCLES(TO), .BASE_SRC_PORT(BASE), .ISN_BASE(32'h1000_0000)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .cfg_src_ip(cfg_src_ip), .cfg_dst_ip(cfg_dst_ip), .cfg_dst_port(cfg_dst_port),
        .tx_tcp_hdr_val(tx_tcp_hdr_val), .tx_src_ip(tx_src_ip), .tx_dst_ip(tx_dst_ip),
        .tx_tcp_hdr(tx_tcp_hdr), .tx_tcp_hdr_rdy(tx_tcp_hdr_rdy),
        .rx_tcp_hdr_val(rx_tcp_hdr_val), .rx_tcp_hdr(rx_tcp_hdr), .rx_tcp_hdr_rdy(rx_tcp_hdr_rdy),
        .busy(busy), .done(done), .pass_count(pass_count), .fail_count(fail_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        chk_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic hdr_t mk(input logic [15:0] sp, input logic [15:0] dp,
                                input logic [31:0] sq, input logic [31:0] ak, input logic [8:0] fl);
        hdr_t h = '0;
        h.src_port = sp;
        h.dst_port = dp;
        h.seq_num  = sq;
        h.ack_num  = ak;
        h.flags    = fl;
        return h;
    endfunction

    function automatic hdr_t syn_exp(input int i);
        return mk(BASE + 16'(i), DPORT, isn_tab[i], isn_tab[i], F_SYN);
    endfunction

    function automatic hdr_t ack_exp(input int i);
        return mk(BASE + 16'(i), DPORT, isn_tab[i] + 32'd1, ack_tab[i], F_ACK);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done();
        for (int k = 0; k < 400; k++) begin
            if (done) break;
            tick();
        end
        chk("done_reached", done, 1'b1);
    endtask

    task automatic cmp_log(input string tag);
        chk({tag, "_len"}, log_q.size(), exp_q.size());
        for (int k = 0; k < log_q.size() && k < exp_q.size(); k++)
            chk($sformatf("%s_hdr%0d", tag, k), log_q[k], exp_q[k]);
    endtask

    // Transaction monitor plus echo responder: replies one cycle after each SYN.
    initial begin
        bit   txhs, rxhs;
        hdr_t txh;
        int   ci;
        forever begin
            @(negedge clk);
            txhs = tx_tcp_hdr_val && tx_tcp_hdr_rdy;
            rxhs = rx_tcp_hdr_val && rx_tcp_hdr_rdy;
            txh  = hdr_t'(tx_tcp_hdr);
            @(posedge clk);
            cyc++;
            #1;
            if (rxhs) rx_tcp_hdr_val = 1'b0;
            if (txhs) begin
                log_q.push_back(txh);
                log_cyc.push_back(cyc);
                ci = int'(txh.src_port) - int'(BASE);
                if (echo_en && txh.flags == F_SYN && ci >= 0 && ci < NC && ci != skip_idx) begin
                    rx_tcp_hdr = mk(txh.dst_port, txh.src_port, echo_seq[ci],
                                    txh.seq_num + ((ci == bad_idx) ? 32'd2 : 32'd1), F_SYN | F_ACK);
                    rx_tcp_hdr_val = 1'b1;
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", err_cnt);
        $fatal(1, "watchdog");
    end

    initial begin
        bit   saw_val;
        int   nsyn;
        rst_n = 1'b0; start = 1'b0;
        cfg_src_ip = 32'hC0A8_0001; cfg_dst_ip = 32'hC0A8_0002; cfg_dst_port = DPORT;
        tx_tcp_hdr_rdy = 1'b1; rx_tcp_hdr_val = 1'b0; rx_tcp_hdr = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_val", tx_tcp_hdr_val, 1'b0);
        chk("rst_hdr", tx_tcp_hdr, '0);
        chk("rst_src_ip", tx_src_ip, '0);
        chk("rst_dst_ip", tx_dst_ip, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_pass", pass_count, 8'd0);
        chk("rst_fail", fail_count, 8'd0);
        chk("rst_rx_rdy", rx_tcp_hdr_rdy, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        #1;
        chk("rx_rdy_before_edge", rx_tcp_hdr_rdy, 1'b0);
        tick();
        chk("rx_rdy_after_edge", rx_tcp_hdr_rdy, 1'b1);

        // Loopback run; cfg_dst_port changes after start must not leak in.
        log_q.delete(); log_cyc.delete();
        pulse_start();
        cfg_dst_port = 16'd99;
        chk("first_syn_val", tx_tcp_hdr_val, 1'b1);
        chk("first_syn_busy", busy, 1'b1);
        chk("first_syn_hdr", tx_tcp_hdr, syn_exp(0));
        wait_done();
        exp_q.delete();
        for (int i = 0; i < NC; i++) begin
            exp_q.push_back(syn_exp(i));
            exp_q.push_back(ack_exp(i));
        end
        cmp_log("loop");
        chk("loop_pass", pass_count, 8'd4);
        chk("loop_fail", fail_count, 8'd0);
        chk("loop_busy", busy, 1'b0);
        chk("loop_src_ip", tx_src_ip, 32'hC0A8_0001);
        chk("loop_dst_ip", tx_dst_ip, 32'hC0A8_0002);
        cfg_dst_port = DPORT;

        // Backpressure during SYN 0.
        log_q.delete(); log_cyc.delete();
        tx_tcp_hdr_rdy = 1'b0;
        pulse_start();
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("stall_val%0d", k), tx_tcp_hdr_val, 1'b1);
            chk($sformatf("stall_hdr%0d", k), tx_tcp_hdr, syn_exp(0));
            tick();
        end
        tx_tcp_hdr_rdy = 1'b1;
        wait_done();
        nsyn = 0;
        foreach (log_q[k]) if (log_q[k].flags == F_SYN && log_q[k].src_port == BASE) nsyn++;
        chk("stall_syn0_count", nsyn, 1);
        chk("stall_pass", pass_count, 8'd4);

        // Bad ack_num on connection 1.
        log_q.delete(); log_cyc.delete();
        bad_idx = 1;
        pulse_start();
        wait_done();
        bad_idx = -1;
        exp_q.delete();
        exp_q.push_back(syn_exp(0)); exp_q.push_back(ack_exp(0));
        exp_q.push_back(syn_exp(1));
        exp_q.push_back(syn_exp(2)); exp_q.push_back(ack_exp(2));
        exp_q.push_back(syn_exp(3)); exp_q.push_back(ack_exp(3));
        cmp_log("bad");
        chk("bad_fail", fail_count, 8'd1);
        chk("bad_pass", pass_count, 8'd3);

        // No reply to connection 0: SYN 1 shows up 17 cycles after the SYN 0
        // handshake and is accepted on the following edge.
        log_q.delete(); log_cyc.delete();
        skip_idx = 0;
        pulse_start();
        wait_done();
        skip_idx = -1;
        chk("to_len_ok", log_q.size() >= 2, 1'b1);
        if (log_q.size() >= 2) begin
            chk("to_gap", log_cyc[1] - log_cyc[0], 18);
            chk("to_syn1", log_q[1], syn_exp(1));
        end
        chk("to_fail", fail_count, 8'd1);
        chk("to_pass", pass_count, 8'd3);

        // Start while busy and a stray (well-formed) reply during SEND_SYN are ignored.
        log_q.delete(); log_cyc.delete();
        tx_tcp_hdr_rdy = 1'b0;
        pulse_start();
        rx_tcp_hdr = mk(DPORT, BASE, 32'h0000_5555, isn_tab[0] + 32'd1, F_SYN | F_ACK);
        rx_tcp_hdr_val = 1'b1;
        start = 1'b1;
        tick();
        rx_tcp_hdr_val = 1'b0;
        start = 1'b0;
        tick();
        tx_tcp_hdr_rdy = 1'b1;
        repeat (3) tick();
        pulse_start();
        chk("ign_busy", busy, 1'b1);
        wait_done();
        exp_q.delete();
        for (int i = 0; i < NC; i++) begin
            exp_q.push_back(syn_exp(i));
            exp_q.push_back(ack_exp(i));
        end
        cmp_log("ign");
        chk("ign_pass", pass_count, 8'd4);
        chk("ign_fail", fail_count, 8'd0);

        // Reset while waiting for the reply to connection 0.
        log_q.delete(); log_cyc.delete();
        echo_en = 1'b0;
        pulse_start();
        for (int k = 0; k < 20; k++) begin
            if (log_q.size() != 0) break;
            tick();
        end
        tick();
        rst_n = 1'b0;
        #1;
        chk("mrst_val", tx_tcp_hdr_val, 1'b0);
        chk("mrst_hdr", tx_tcp_hdr, '0);
        chk("mrst_src_ip", tx_src_ip, '0);
        chk("mrst_dst_ip", tx_dst_ip, '0);
        chk("mrst_busy", busy, 1'b0);
        chk("mrst_done", done, 1'b0);
        chk("mrst_rx_rdy", rx_tcp_hdr_rdy, 1'b0);
        tick();
        rst_n = 1'b1;
        saw_val = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (tx_tcp_hdr_val) saw_val = 1'b1;
        end
        chk("mrst_no_tx", saw_val, 1'b0);
        chk("mrst_idle", busy, 1'b0);
        chk("mrst_log", log_q.size(), 1);
        echo_en = 1'b1;
        log_q.delete(); log_cyc.delete();
        pulse_start();
        chk("mrst_restart_hdr", tx_tcp_hdr, syn_exp(0));
        wait_done();
        chk("mrst_pass", pass_count, 8'd4);
        chk("mrst_fail", fail_count, 8'd0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
